// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
//   fetch PC, issues one outstanding request at a time on a req/gnt/rvalid
//   instruction-memory port, buffers the returned instruction until the
//   downstream register accepts it, and applies redirects from later stages.
//   A response is discarded when a redirect has made it stale.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   stall_n        : downstream accept (IF/ID register loads when 1)
//   redirect_valid : redirect fetch to redirect_pc
//   redirect_pc    : redirect target (bits [1:0] forced to zero)
//   imem_req       : memory request valid
//   imem_addr      : request address (current fetch PC)
//   imem_gnt       : request accepted this cycle
//   imem_rvalid    : response valid
//   imem_rdata     : response instruction
//   pc_if_o        : PC of the buffered instruction
//   instr_if_o     : buffered instruction
//   inst_valid_o   : buffer holds a valid instruction
//   bubble_o       : IF/ID flush, ~inst_valid_o | redirect_valid
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | one idle cycle after reset, no request
// REQ   | request driven at pc_r, waiting for gnt
// WAIT  | request granted, waiting for rvalid (drop marks it stale)
// HOLD  | instruction buffered, waiting for downstream accept
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int               XLEN     = 64,
   parameter int               INST_LEN = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 'h8000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall_n,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INST_LEN-1:0] imem_rdata,
   output logic [XLEN-1:0]     pc_if_o,
   output logic [INST_LEN-1:0] instr_if_o,
   output logic                inst_valid_o,
   output logic                bubble_o
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic                drop_q, drop_d;
   logic [XLEN-1:0]     buf_pc_q, buf_pc_d;
   logic [INST_LEN-1:0] buf_instr_q, buf_instr_d;
   logic                valid_q, valid_d;
   logic [XLEN-1:0]     redirect_tgt;

   assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_d      = drop_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      valid_d     = valid_q;
      imem_req    = 1'b0;
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            imem_req = 1'b1;
            if (redirect_valid) pc_d = redirect_tgt;
            if (imem_gnt) begin
               state_d = S_WAIT;
               // a redirect accepted together with gnt makes the response stale
               drop_d  = redirect_valid;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
               if (drop_q) begin
                  drop_d = 1'b0;
                  if (redirect_valid) pc_d = redirect_tgt;
               end else if (redirect_valid) begin
                  pc_d = redirect_tgt;
               end else begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc_q;
                  pc_d        = pc_q + XLEN'(4);
                  valid_d     = 1'b1;
                  state_d     = S_HOLD;
               end
            end else if (redirect_valid) begin
               pc_d   = redirect_tgt;
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redirect_tgt;
               state_d = S_REQ;
            end else if (stall_n) begin
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   assign imem_addr    = pc_q;
   assign pc_if_o      = buf_pc_q;
   assign instr_if_o   = buf_instr_q;
   assign inst_valid_o = valid_q;
   assign bubble_o     = ~valid_q | redirect_valid;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues single-outstanding requests to the instruction memory over a req/gnt/rvalid interface.
- Buffers each returned instruction until the downstream register accepts it (stall_n high).
- Applies branch/jump redirects from later stages, discarding stale in-flight responses.

Parameters:
- XLEN, 64, PC and address width.
- INST_LEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_n  input  1  downstream accept; 1 = IF/ID register loads this cycle.
- redirect_valid  input  1  redirect fetch to redirect_pc.
- redirect_pc  input  XLEN  redirect target; bits [1:0] are forced to 0.
- imem_req  output  1  memory request valid.
- imem_addr  output  XLEN  request address; always equals pc_r.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; at most one per accepted request, at least 1 cycle after gnt.
- imem_rdata  input  INST_LEN  response instruction.
- pc_if_o  output  XLEN  PC of the buffered instruction.
- instr_if_o  output  INST_LEN  buffered instruction.
- inst_valid_o  output  1  buffer holds a valid instruction.
- bubble_o  output  1  drives the IF/ID flush: ~inst_valid_o | redirect_valid.

Behaviour:
- Reset is asynchronous: state=BOOT, pc_r=RESET_PC, drop=0, buf_pc=0, buf_instr=0.
- Reset values of outputs: imem_req=0, imem_addr=RESET_PC, pc_if_o=0, instr_if_o=0, inst_valid_o=0, bubble_o=1.
- Reset asserted mid-transaction abandons it; a late rvalid arriving in BOOT is ignored.
- BOOT: imem_req=0 for one cycle, then go to REQ.
- REQ: imem_req=1.
  - gnt without redirect: go to WAIT.
  - redirect without gnt: pc_r<=redirect_pc, stay in REQ.
  - gnt and redirect in the same cycle: pc_r<=redirect_pc, drop<=1, go to WAIT.
- WAIT: imem_req=0.
  - rvalid with drop=1: discard data, drop<=0, go to REQ.
  - rvalid with drop=0 and no redirect: buf_instr<=rdata, buf_pc<=pc_r, pc_r<=pc_r+4, inst_valid<=1, go to HOLD.
  - rvalid and redirect in the same cycle: discard data, pc_r<=redirect_pc, go to REQ, drop stays 0.
  - redirect without rvalid: pc_r<=redirect_pc, drop<=1, stay in WAIT.
- HOLD: inst_valid_o=1.
  - redirect (has priority): inst_valid<=0, pc_r<=redirect_pc, go to REQ.
  - otherwise stall_n=1: instruction is consumed at this edge; inst_valid<=0, go to REQ.
  - otherwise stall_n=0: hold pc_if_o and instr_if_o unchanged indefinitely.
- Outputs pc_if_o, instr_if_o and inst_valid_o are registered. buf_pc and buf_instr keep their old value when invalid.
- pc_r+4 wraps modulo 2^XLEN.
- stall_n is ignored whenever inst_valid_o=0.
- At most one request is outstanding. Throughput is 1 instruction per 3 cycles with gnt in REQ's first cycle and rvalid 1 cycle later.
- imem_addr must stay stable while imem_req=1 and gnt=0, except when a redirect changes it.

Test Plan:
- Reset release; memory returns gnt immediately and rvalid 1 cycle later -> first imem_req at cycle 1 with addr 0x8000_0000; then inst_valid_o=1 with pc_if_o=0x8000_0000; subsequent addrs 0x8000_0004, 0x8000_0008.
- HOLD with stall_n=0 for 5 cycles, instr=0x0000_0013 -> outputs constant, imem_req=0 throughout, bubble_o=0; stall_n=1 -> next req to pc+4.
- Redirect to 0x8000_0100 in WAIT; stale rvalid returns 0xDEAD_BEEF 2 cycles later -> data discarded, next req addr 0x8000_0100, inst_valid_o stays 0, bubble_o=1.
- Redirect to 0x8000_0203 coincident with gnt -> stale response dropped; next addr 0x8000_0200.
- pc_r=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr 0x0.
- rst_n low while in WAIT, rvalid arrives during reset -> all outputs at reset values; after release, fetch restarts at 0x8000_0000.
